// File: rtl/clkdiv_multi_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_WIDTH    = 8;

    typedef logic [DEF_WIDTH-1:0] div_t;

    // Width of a channel index; never narrower than one bit.
    function automatic int ch_idx_w(input int n);
        if (n <= 1) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Configuration and status bundle between the controller and the divider block.
interface clkdiv_multi_if
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
);

    localparam int CH_W = ch_idx_w(CHANNELS);

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [WIDTH-1:0]    cfg_div;
    logic [CHANNELS-1:0] clk_out;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] active;
    logic [CHANNELS-1:0] pending;

    modport master (
        output cfg_we, cfg_ch, cfg_div,
        input  clk_out, tick, active, pending
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_div,
        output clk_out, tick, active, pending
    );

endinterface

// File: rtl/clkdiv_multi_channel.sv
// One divider channel: shadow/active ratio, period-boundary apply, counter, toggle and tick.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             active,
    output logic             pending
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] act_d_r;
    logic [WIDTH-1:0] shd_d_r;
    logic             pend_r;
    logic [WIDTH-1:0] cnt_r;
    logic             out_r;
    logic             tick_r;
    logic             active_r;

    logic [WIDTH-1:0] shd_nxt_s;
    logic             pend_in_s;
    logic             terminal_s;
    logic             period_end_s;
    logic             apply_s;
    logic [WIDTH-1:0] act_nxt_s;
    logic             pend_nxt_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             out_nxt_s;
    logic             tick_nxt_s;

    // Next-state logic; a write on the apply edge is forwarded straight into act_d.
    always_comb begin
        shd_nxt_s    = wr_en ? wr_div : shd_d_r;
        pend_in_s    = wr_en | pend_r;
        terminal_s   = (act_d_r != ZERO) && (cnt_r == (act_d_r - ONE));
        // Only a falling toggle ends a period, so applies never cut a high phase short.
        period_end_s = en && terminal_s && out_r;
        apply_s      = pend_in_s && (sync || (act_d_r == ZERO) || period_end_s);

        act_nxt_s  = act_d_r;
        pend_nxt_s = pend_in_s;
        cnt_nxt_s  = cnt_r;
        out_nxt_s  = out_r;
        tick_nxt_s = 1'b0;

        if (apply_s) begin
            act_nxt_s  = shd_nxt_s;
            pend_nxt_s = 1'b0;
            cnt_nxt_s  = ZERO;
            out_nxt_s  = 1'b0;
        end else if (sync) begin
            cnt_nxt_s = ZERO;
            out_nxt_s = 1'b0;
        end else if (act_d_r == ZERO) begin
            cnt_nxt_s = ZERO;
            out_nxt_s = 1'b0;
        end else if (!en) begin
            cnt_nxt_s = cnt_r;
            out_nxt_s = out_r;
        end else if (terminal_s) begin
            cnt_nxt_s  = ZERO;
            out_nxt_s  = ~out_r;
            tick_nxt_s = ~out_r;
        end else begin
            cnt_nxt_s = cnt_r + ONE;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_d_r  <= ZERO;
            shd_d_r  <= ZERO;
            pend_r   <= 1'b0;
            cnt_r    <= ZERO;
            out_r    <= 1'b0;
            tick_r   <= 1'b0;
            active_r <= 1'b0;
        end else begin
            act_d_r  <= act_nxt_s;
            shd_d_r  <= shd_nxt_s;
            pend_r   <= pend_nxt_s;
            cnt_r    <= cnt_nxt_s;
            out_r    <= out_nxt_s;
            tick_r   <= tick_nxt_s;
            active_r <= (act_nxt_s != ZERO);
        end
    end

    assign clk_out = out_r;
    assign tick    = tick_r;
    assign active  = active_r;
    assign pending = pend_r;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: config write decode plus per-channel dividers.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int WIDTH    = DEF_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           en,
    input  logic           sync,
    clkdiv_multi_if.slave  bus
);

    localparam int CH_W = ch_idx_w(CHANNELS);

    wire [CHANNELS-1:0] clk_out_s;
    wire [CHANNELS-1:0] tick_s;
    wire [CHANNELS-1:0] active_s;
    wire [CHANNELS-1:0] pending_s;

    // Indices at or beyond CHANNELS match no channel, so such writes are dropped.
    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        wire wr_en_s = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

        clkdiv_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .sync    (sync),
            .wr_en   (wr_en_s),
            .wr_div  (bus.cfg_div),
            .clk_out (clk_out_s[i]),
            .tick    (tick_s[i]),
            .active  (active_s[i]),
            .pending (pending_s[i])
        );
    end

    assign bus.clk_out = clk_out_s;
    assign bus.tick    = tick_s;
    assign bus.active  = active_s;
    assign bus.pending = pending_s;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Self-checking bench for clkdiv_multi: vector table plus directed multi-cycle sequences.
module tb_clkdiv_multi;
    import clkdiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic sync;

    always #5 clk = ~clk;

    clkdiv_multi_if #(.CHANNELS(4), .WIDTH(8)) bus ();
    clkdiv_multi #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .bus(bus)
    );

    clkdiv_multi_if #(.CHANNELS(3), .WIDTH(8)) bus3 ();
    clkdiv_multi #(.CHANNELS(3), .WIDTH(8)) dut3 (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .bus(bus3)
    );

    typedef struct {
        logic       rst;
        logic       we;
        logic [1:0] ch;
        logic [7:0] div;
        logic [3:0] e_clk;
        logic [3:0] e_tick;
        logic [3:0] e_act;
        logic [3:0] e_pend;
    } vec_t;

    vec_t tbl [18];
    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int d);
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = ch[1:0];
        bus.cfg_div = d[7:0];
        step();
        bus.cfg_we  = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wave(input string nm, input int ch, input string pat);
        for (int i = 0; i < pat.len(); i++) begin
            step();
            check($sformatf("%s[%0d]", nm, i), {31'd0, bus.clk_out[ch]},
                  {31'd0, (pat.substr(i, i) == "1")});
        end
    endtask

    logic [3:0] sync_exp [6];

    initial begin
        rst = 1'b1; en = 1'b1; sync = 1'b0;
        bus.cfg_we = 1'b0;  bus.cfg_ch = 2'd0;  bus.cfg_div = 8'd0;
        bus3.cfg_we = 1'b0; bus3.cfg_ch = 2'd0; bus3.cfg_div = 8'd0;

        //             rst   we    ch    div    clk   tick  act   pend
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{1'b0, 1'b1, 2'd0, 8'd3, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[2]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[3]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h1, 4'h1, 4'h1, 4'h0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h1, 4'h0, 4'h1, 4'h0};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h1, 4'h0, 4'h1, 4'h0};
        tbl[7]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h1, 4'h1, 4'h1, 4'h0};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h1, 4'h0, 4'h1, 4'h0};
        tbl[12] = '{1'b1, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[13] = '{1'b0, 1'b1, 2'd1, 8'd1, 4'h0, 4'h0, 4'h2, 4'h0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h2, 4'h2, 4'h2, 4'h0};
        tbl[15] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h2, 4'h0};
        tbl[16] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h2, 4'h2, 4'h2, 4'h0};
        tbl[17] = '{1'b0, 1'b0, 2'd0, 8'd0, 4'h0, 4'h0, 4'h2, 4'h0};

        for (int i = 0; i < 18; i++) begin
            rst         = tbl[i].rst;
            bus.cfg_we  = tbl[i].we;
            bus.cfg_ch  = tbl[i].ch;
            bus.cfg_div = tbl[i].div;
            step();
            check($sformatf("vec%0d clk_out", i), {28'd0, bus.clk_out}, {28'd0, tbl[i].e_clk});
            check($sformatf("vec%0d tick", i),    {28'd0, bus.tick},    {28'd0, tbl[i].e_tick});
            check($sformatf("vec%0d active", i),  {28'd0, bus.active},  {28'd0, tbl[i].e_act});
            check($sformatf("vec%0d pending", i), {28'd0, bus.pending}, {28'd0, tbl[i].e_pend});
        end
        rst = 1'b0;
        bus.cfg_we = 1'b0;

        // Ratio change D=4 -> D=2 in the high phase of ch1.
        do_rst();
        wr(1, 4);
        wave("chg_pre", 1, "00011");
        wr(1, 2);
        check("chg_wr clk", {31'd0, bus.clk_out[1]}, 32'd1);
        check("chg_wr pend", {31'd0, bus.pending[1]}, 32'd1);
        step();
        check("chg_hold clk", {31'd0, bus.clk_out[1]}, 32'd1);
        check("chg_hold pend", {31'd0, bus.pending[1]}, 32'd1);
        wave("chg_post", 1, "0011001");
        check("chg_done pend", {31'd0, bus.pending[1]}, 32'd0);

        // Disable ch2 (D=5) during its high phase.
        do_rst();
        wr(2, 5);
        wave("dis_pre", 2, "000011");
        wr(2, 0);
        check("dis_wr clk", {31'd0, bus.clk_out[2]}, 32'd1);
        check("dis_wr act", {31'd0, bus.active[2]}, 32'd1);
        check("dis_wr pend", {31'd0, bus.pending[2]}, 32'd1);
        wave("dis_high", 2, "11");
        step();
        check("dis_fall clk", {31'd0, bus.clk_out[2]}, 32'd0);
        check("dis_fall act", {31'd0, bus.active[2]}, 32'd0);
        check("dis_fall pend", {31'd0, bus.pending[2]}, 32'd0);
        wave("dis_idle", 2, "00000000000");

        // Sync realigns ch0 (D=2) and ch3 (D=3).
        do_rst();
        wr(0, 2);
        wr(3, 3);
        repeat (4) step();
        check("sync_pre clk", {28'd0, bus.clk_out}, 32'h8);
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sync_edge clk", {28'd0, bus.clk_out}, 32'h0);
        check("sync_edge tick", {28'd0, bus.tick}, 32'h0);
        sync_exp[0] = 4'h0; sync_exp[1] = 4'h1; sync_exp[2] = 4'h9;
        sync_exp[3] = 4'h8; sync_exp[4] = 4'h8; sync_exp[5] = 4'h1;
        for (int i = 0; i < 6; i++) begin
            step();
            check($sformatf("sync_after%0d clk", i + 1), {28'd0, bus.clk_out}, {28'd0, sync_exp[i]});
        end

        // Freeze ch0 (D=4) just after its rising edge; idle ch2 still loads.
        do_rst();
        wr(0, 4);
        wave("frz_pre", 0, "0001");
        en = 1'b0;
        wr(2, 1);
        check("frz_load act2", {31'd0, bus.active[2]}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check($sformatf("frz%0d clk", i), {31'd0, bus.clk_out[0]}, 32'd1);
            check($sformatf("frz%0d tick", i), {31'd0, bus.tick[0]}, 32'd0);
        end
        en = 1'b1;
        wave("frz_resume", 0, "11100001");

        // Maximum divide value on ch3.
        do_rst();
        wr(3, 255);
        repeat (254) step();
        check("max_low clk", {31'd0, bus.clk_out[3]}, 32'd0);
        step();
        check("max_rise clk", {31'd0, bus.clk_out[3]}, 32'd1);
        check("max_rise tick", {31'd0, bus.tick[3]}, 32'd1);
        repeat (254) step();
        check("max_high clk", {31'd0, bus.clk_out[3]}, 32'd1);
        step();
        check("max_fall clk", {31'd0, bus.clk_out[3]}, 32'd0);

        // Out-of-range channel index on the 3-channel build.
        do_rst();
        bus3.cfg_we  = 1'b1;
        bus3.cfg_ch  = 2'd3;
        bus3.cfg_div = 8'd1;
        step();
        check("oor active", {29'd0, bus3.active}, 32'h0);
        check("oor pending", {29'd0, bus3.pending}, 32'h0);
        bus3.cfg_ch = 2'd2;
        step();
        bus3.cfg_we = 1'b0;
        check("ch2 active", {29'd0, bus3.active}, 32'h4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
